// File: rtl/edge_arb_pkg.sv
// Shared types and constants for the edge event arbiter.
package edge_arb_pkg;

  // Default number of input channels.
  localparam int N_CH_DEF = 4;

  // Output slot state: IDLE means the slot is empty, VALID means an event is presented.
  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_e;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// Combinational round-robin finder: first set bit of req_i at or above
// ptr_i, wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         any_o,
  output logic [W-1:0] idx_o
);

  localparam logic [W:0] N_V = (W+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;
  logic [W:0]     sum;

  // Rotate the request vector so ptr_i lands at bit 0, take the lowest set
  // bit, then add ptr_i back modulo N to get the absolute channel index.
  always_comb begin
    dbl   = {req_i, req_i} >> ptr_i;
    rot   = dbl[N-1:0];
    any_o = 1'b0;
    off   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        any_o = 1'b1;
        off   = W'(j);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= N_V) begin
      idx_o = W'(sum - N_V);
    end else begin
      idx_o = W'(sum);
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel rising-edge event collector with a one-deep per-channel
// queue and a single round-robin output slot.
//
// Handshake: out_valid/out_id are registered. Once out_valid is high it stays
// high and out_id stays stable until a cycle with out_valid & out_ready; that
// cycle transfers the event, and a next event may be loaded in the same cycle.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  localparam int ID_W = id_w(N_CH)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N_CH-1:0] din,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ID_W-1:0] out_id,
  output logic [N_CH-1:0] ovf,
  input  logic            ovf_clr,
  output state_e          dbg_state
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [N_CH-1:0]   prev_q;
  logic [N_CH-1:0]   pend_q, pend_d;
  logic [N_CH-1:0]   ovf_q, ovf_d;

  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   slot_oh;
  logic [N_CH-1:0]   cand;
  logic [N_CH-1:0]   load_oh;
  logic [N_CH-1:0]   ovf_set;
  logic              hs;
  logic              load;
  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;

  // Candidate events: pending plus fresh rises. The channel sitting in the
  // slot is masked unless it has just risen again.
  always_comb begin
    rise    = din & ~prev_q;
    slot_oh = '0;
    if (state_q == VALID) begin
      slot_oh[id_q] = 1'b1;
    end
    cand = (pend_q | rise) & ~(slot_oh & ~rise);
  end

  rr_pick #(
    .N (N_CH),
    .W (ID_W)
  ) u_pick (
    .req_i (cand),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  // Slot FSM: load when empty or when the current event is handed off.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hs      = (state_q == VALID) && out_ready;
    load    = ((state_q == IDLE) || hs) && pick_any;
    load_oh = '0;
    if (load) begin
      load_oh[pick_idx] = 1'b1;
      state_d = VALID;
      id_d    = pick_idx;
      ptr_d   = (pick_idx == ID_W'(N_CH - 1)) ? '0 : pick_idx + 1'b1;
    end else if (hs) begin
      state_d = IDLE;
    end
  end

  // Pending and overflow update. A loaded channel frees its pending bit, so
  // a coincident rise on it refills pending instead of overflowing.
  always_comb begin
    pend_d  = (load_oh & pend_q & rise) | (~load_oh & (pend_q | rise));
    ovf_set = rise & pend_q & ~load_oh;
    ovf_d   = (ovf_clr ? '0 : ovf_q) | ovf_set;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      id_q    <= '0;
      ptr_q   <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      prev_q  <= din;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == VALID);
  assign out_id    = id_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule
